// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control slice.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hcu_state_e;

    // Canonical NOP (addi x0, x0, 0) loaded by pipeline registers on flush/bubble.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Detects hazards forwarding cannot cover (load-use, multi-cycle EX ops, taken
// branches) and drives PC / IF/ID / ID/EX stall, bubble and flush controls.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MC_TIMEOUT     = 64,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rs2,
    input  logic                      IF_ID_UseRs1,
    input  logic                      IF_ID_UseRs2,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_Rd,
    input  logic                      ID_EX_MemRead,
    input  logic                      ID_EX_MultiCycle,
    input  logic                      mc_done,
    input  logic                      EX_BranchTaken,
    output logic                      PC_Write,
    output logic                      IF_ID_Write,
    output logic                      IF_ID_Flush,
    output logic                      ID_EX_Bubble,
    output logic                      EX_Hold,
    output logic                      mc_timeout,
    output logic [CNT_WIDTH-1:0]      stall_cycles
);

    localparam int unsigned TMO_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 1);

    hcu_state_e       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mc_timeout_q, mc_timeout_d;
    logic             load_use;

    assign load_use = ID_EX_MemRead && (ID_EX_Rd != '0) &&
                      ((IF_ID_UseRs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                       (IF_ID_UseRs2 && (ID_EX_Rd == IF_ID_Rs2)));

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        EX_Hold      = 1'b0;
        state_d      = state_q;
        tmo_d        = tmo_q;
        mc_timeout_d = mc_timeout_q;

        if (rst) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    // Taken branch squashes the ID instruction, so it masks load-use.
                    if (EX_BranchTaken) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else if (load_use) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end
                    if (ID_EX_MultiCycle && !EX_BranchTaken) begin
                        state_d = MC_WAIT;
                        tmo_d   = '0;
                    end
                end
                MC_WAIT: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    EX_Hold     = 1'b1;
                    // mc_done is checked first so a coincident timeout is not an error.
                    if (mc_done) begin
                        state_d = RUN;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d      = RUN;
                        tmo_d        = '0;
                        mc_timeout_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    tmo_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            tmo_q        <= '0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign mc_timeout = mc_timeout_q;

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (!PC_Write && !rst),
        .clr_i  (rst),
        .count_o(stall_cycles)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: table-driven RUN-state vectors plus
// hand-written multi-cycle, timeout, reset and saturation sequences.
module tb_hazard_control_unit;

    localparam logic [4:0] CTL_RUN = 5'b11000;  // {PC_Write, IF_ID_Write, Flush, Bubble, Hold}
    localparam logic [4:0] CTL_LU  = 5'b00010;
    localparam logic [4:0] CTL_BR  = 5'b11110;
    localparam logic [4:0] CTL_MC  = 5'b00001;
    localparam logic [4:0] CTL_RST = 5'b00110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memrd, multi, done, br;

    logic        pcw0, ifw0, fl0, bb0, hd0, to0;
    logic [15:0] sc0;
    logic        pcw1, ifw1, fl1, bb1, hd1, to1;
    logic [15:0] sc1;
    logic        pcw2, ifw2, fl2, bb2, hd2, to2;
    logic [3:0]  sc2;
    logic [4:0]  ctl0, ctl1, ctl2;

    assign ctl0 = {pcw0, ifw0, fl0, bb0, hd0};
    assign ctl1 = {pcw1, ifw1, fl1, bb1, hd1};
    assign ctl2 = {pcw2, ifw2, fl2, bb2, hd2};

    always #5 clk = ~clk;

    hazard_control_unit dut0 (
        .clk(clk), .rst(rst), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2),
        .IF_ID_UseRs1(use1), .IF_ID_UseRs2(use2), .ID_EX_Rd(rd),
        .ID_EX_MemRead(memrd), .ID_EX_MultiCycle(multi), .mc_done(done),
        .EX_BranchTaken(br), .PC_Write(pcw0), .IF_ID_Write(ifw0),
        .IF_ID_Flush(fl0), .ID_EX_Bubble(bb0), .EX_Hold(hd0),
        .mc_timeout(to0), .stall_cycles(sc0)
    );

    hazard_control_unit #(.MC_TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2),
        .IF_ID_UseRs1(use1), .IF_ID_UseRs2(use2), .ID_EX_Rd(rd),
        .ID_EX_MemRead(memrd), .ID_EX_MultiCycle(multi), .mc_done(done),
        .EX_BranchTaken(br), .PC_Write(pcw1), .IF_ID_Write(ifw1),
        .IF_ID_Flush(fl1), .ID_EX_Bubble(bb1), .EX_Hold(hd1),
        .mc_timeout(to1), .stall_cycles(sc1)
    );

    hazard_control_unit #(.MC_TIMEOUT(64), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2),
        .IF_ID_UseRs1(use1), .IF_ID_UseRs2(use2), .ID_EX_Rd(rd),
        .ID_EX_MemRead(memrd), .ID_EX_MultiCycle(multi), .mc_done(done),
        .EX_BranchTaken(br), .PC_Write(pcw2), .IF_ID_Write(ifw2),
        .IF_ID_Flush(fl2), .ID_EX_Bubble(bb2), .EX_Hold(hd2),
        .mc_timeout(to2), .stall_cycles(sc2)
    );

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       use1, use2, memrd, done, br;
        logic [4:0] exp_ctl;
    } vec_t;

    vec_t vecs[10];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs1 = '0; rs2 = '0; rd = '0;
        use1 = 1'b0; use2 = 1'b0; memrd = 1'b0; multi = 1'b0; done = 1'b0; br = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs are driven here and sampled 4 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic do_reset();
        next_cycle();
        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int exp_stall;

        vecs[0] = '{"idle",        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN};
        vecs[1] = '{"lu_rs1",      5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CTL_LU};
        vecs[2] = '{"lu_rs2",      5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CTL_LU};
        vecs[3] = '{"x0_dest",     5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CTL_RUN};
        vecs[4] = '{"rs2_unused",  5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CTL_RUN};
        vecs[5] = '{"no_load",     5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN};
        vecs[6] = '{"br_over_lu",  5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, CTL_BR};
        vecs[7] = '{"br_alone",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CTL_BR};
        vecs[8] = '{"done_in_run", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CTL_RUN};
        vecs[9] = '{"rd_mismatch", 5'd6, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CTL_RUN};

        idle();
        rst = 1'b1;
        next_cycle();
        settle();
        chk("reset_ctl", 32'(ctl0), 32'(CTL_RST));
        next_cycle();
        rst = 1'b0;
        settle();
        chk("reset_stall", 32'(sc0), 32'd0);
        chk("reset_timeout", 32'(to0), 32'd0);
        chk("post_reset_ctl", 32'(ctl0), 32'(CTL_RUN));

        // Table-driven single-cycle RUN behaviour
        exp_stall = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            idle();
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; rd = vecs[i].rd;
            use1 = vecs[i].use1; use2 = vecs[i].use2; memrd = vecs[i].memrd;
            done = vecs[i].done; br = vecs[i].br;
            settle();
            chk(vecs[i].name, 32'(ctl0), 32'(vecs[i].exp_ctl));
            if (!vecs[i].exp_ctl[4]) exp_stall++;
        end
        next_cycle();
        idle();
        settle();
        chk("table_stall", 32'(sc0), 32'(exp_stall));

        // Load-use: one stall cycle, then defaults once the bubble clears MemRead
        do_reset();
        rs1 = 5'd5; use1 = 1'b1; rd = 5'd5; memrd = 1'b1;
        settle();
        chk("lu_cycle", 32'(ctl0), 32'(CTL_LU));
        next_cycle();
        memrd = 1'b0;
        settle();
        chk("lu_after", 32'(ctl0), 32'(CTL_RUN));
        chk("lu_stall", 32'(sc0), 32'd1);
        next_cycle();
        memrd = 1'b1; br = 1'b1;
        settle();
        chk("br_lu_ctl", 32'(ctl0), 32'(CTL_BR));
        next_cycle();
        idle();
        settle();
        chk("br_lu_stall", 32'(sc0), 32'd1);

        // Multi-cycle op issued with a taken branch must not enter MC_WAIT
        multi = 1'b1; br = 1'b1;
        settle();
        chk("mc_br_issue", 32'(ctl0), 32'(CTL_BR));
        next_cycle();
        idle();
        settle();
        chk("mc_br_next", 32'(ctl0), 32'(CTL_RUN));

        // Multi-cycle op: issue at cycle 0, mc_done at cycle 10
        do_reset();
        multi = 1'b1;
        settle();
        chk("mc_issue", 32'(ctl0), 32'(CTL_RUN));
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            idle();
            if (c == 3) begin
                br = 1'b1; memrd = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
            end
            if (c == 10) done = 1'b1;
            settle();
            chk($sformatf("mc_wait_c%0d", c), 32'(ctl0), 32'(CTL_MC));
        end
        next_cycle();
        idle();
        settle();
        chk("mc_resume", 32'(ctl0), 32'(CTL_RUN));
        chk("mc_stall", 32'(sc0), 32'd10);
        chk("mc_no_timeout", 32'(to0), 32'd0);

        // Timeout on dut1 (MC_TIMEOUT=8): 8 MC_WAIT cycles, then RUN with sticky error
        do_reset();
        multi = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            idle();
            settle();
            chk($sformatf("tmo_wait_c%0d", c), 32'(ctl1), 32'(CTL_MC));
        end
        chk("tmo_not_yet", 32'(to1), 32'd0);
        next_cycle();
        settle();
        chk("tmo_run", 32'(ctl1), 32'(CTL_RUN));
        chk("tmo_flag", 32'(to1), 32'd1);
        chk("tmo_stall", 32'(sc1), 32'd8);
        for (int c = 0; c < 5; c++) next_cycle();
        settle();
        chk("tmo_sticky", 32'(to1), 32'd1);
        next_cycle();
        rst = 1'b1;
        settle();
        chk("tmo_rst_ctl", 32'(ctl1), 32'(CTL_RST));
        next_cycle();
        rst = 1'b0;
        settle();
        chk("tmo_rst_flag", 32'(to1), 32'd0);
        chk("tmo_rst_stall", 32'(sc1), 32'd0);
        chk("tmo_rst_run", 32'(ctl1), 32'(CTL_RUN));

        // mc_done coinciding with the timeout cycle wins
        multi = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            idle();
            if (c == 8) done = 1'b1;
        end
        next_cycle();
        idle();
        settle();
        chk("tie_run", 32'(ctl1), 32'(CTL_RUN));
        chk("tie_no_flag", 32'(to1), 32'd0);

        // Reset in the middle of MC_WAIT discards the pending op
        next_cycle();
        multi = 1'b1;
        next_cycle();
        idle();
        next_cycle();
        settle();
        chk("mid_wait", 32'(ctl0), 32'(CTL_MC));
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        settle();
        chk("mid_rst_run", 32'(ctl0), 32'(CTL_RUN));

        // Saturation on dut2 (CNT_WIDTH=4): 20 MC_WAIT cycles
        do_reset();
        multi = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            idle();
        end
        settle();
        chk("sat_still_wait", 32'(ctl2), 32'(CTL_MC));
        next_cycle();
        done = 1'b1;
        settle();
        chk("sat_value", 32'(sc2), 32'd15);
        next_cycle();
        idle();
        settle();
        chk("sat_hold", 32'(sc2), 32'd15);
        chk("sat_run", 32'(ctl2), 32'(CTL_RUN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
